// File: rtl/fb_pkg.sv
// Shared framebuffer definitions for the Game Boy capture / VGA path.
// Holds the framebuffer geometry, the pixel address/data types, the
// entry format carried by the write FIFO and the arbiter grant encoding.
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 144;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 2;

    typedef logic [ADDR_W-1:0] pixAddr_t;
    typedef logic [DATA_W-1:0] pixData_t;

    // One queued capture pixel: where it goes and what shade it is.
    typedef struct packed {
        pixAddr_t addr;
        pixData_t data;
    } wrEntry_t;

    // Which client owns the RAM port in the current cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_WRITE = 2'd1,
        GNT_READ  = 2'd2
    } grant_e;

    // True when the pixel address falls inside the 160x144 frame.
    function automatic logic inRange(input pixAddr_t a);
        return a < pixAddr_t'(FB_PIXELS);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO for the capture path.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset, empties the FIFO
//   flush_i      drops every queued entry on the next edge
//   push_i       enqueue pushEntry_i (ignored when full or flushing)
//   pushEntry_i  {addr,data} of the pixel to queue
//   pop_i        dequeue the head entry (ignored when empty or flushing)
//   head_o       oldest queued entry
//   level_o      number of queued entries
//   full_o       level_o == DEPTH
//   empty_o      level_o == 0
// There is no bypass path: an entry pushed this cycle is visible at the
// head at the earliest on the next cycle.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  wrEntry_t         pushEntry_i,
    input  logic             pop_i,
    output wrEntry_t         head_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    wrEntry_t         storage_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             doPush, doPop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign head_o  = storage_q[rdPtr_q];
    assign level_o = level_q;
    assign doPush  = push_i & ~full_o & ~flush_i;
    assign doPop   = pop_i & ~empty_o & ~flush_i;

    // Pointer and level bookkeeping; DEPTH is a power of two so the
    // pointers simply wrap.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(doPush) - LVL_W'(doPop);
        end
    end

    // State registers; the storage array itself needs no reset because
    // nothing reads it while the level is zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
            if (doPush) begin
                storage_q[wrPtr_q] <= pushEntry_i;
            end
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port 160x144x2bpp framebuffer RAM between the capture
// writer (buffered through fb_wr_fifo) and the VGA line prefetcher.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   FLUSH               drop all queued writes (frame abort)
//   WR_VALID/ADDR/DATA  capture pixel; accepted when WR_READY is high
//   WR_READY            FIFO can take a pixel this cycle
//   RD_REQ/RD_ADDR      prefetch request, held until RD_GNT
//   RD_GNT              read issued to the RAM this cycle
//   RD_VALID/RD_DATA    read result, one cycle after RD_GNT
//   MEM_EN/WE/ADDR/WDATA  RAM command port (all zero when idle)
//   MEM_RDATA           RAM read data, one cycle after a read command
//   FIFO_LEVEL          number of queued writes
//   ERR_OOR             sticky out-of-range address flag
// Reads normally win; a pending write forces its way in when the FIFO is
// nearly full or has been denied STARVE_MAX cycles in a row.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter int  STARVE_MAX = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              WR_VALID,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_READY,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_GNT,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [LVL_W-1:0]  FIFO_LEVEL,
    output logic              ERR_OOR
);

    wrEntry_t            pushEntry, head;
    logic [LVL_W-1:0]    level;
    logic                full, empty, push, popHead;
    logic                pend, urgent, oorHit;
    grant_e              grant;
    logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;
    logic                rdValid_q, rdValid_d;
    logic                rdOor_q, rdOor_d;
    logic                errOor_q, errOor_d;

    assign WR_READY  = ~full & ~FLUSH & ~RST;
    assign push      = WR_VALID & WR_READY;
    assign pushEntry = '{addr: WR_ADDR, data: WR_DATA};
    assign popHead   = (grant == GNT_WRITE);

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wrFifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .flush_i    (FLUSH),
        .push_i     (push),
        .pushEntry_i(pushEntry),
        .pop_i      (popHead),
        .head_o     (head),
        .level_o    (level),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Arbitration: a queued write only yields to a read while it is
    // neither urgent nor starved.
    always_comb begin
        grant  = GNT_IDLE;
        pend   = ~empty & ~FLUSH & ~RST;
        urgent = (level >= LVL_W'(FIFO_DEPTH - 1))
               | (starveCnt_q == STARVE_W'(STARVE_MAX));
        if (pend && (!RD_REQ || urgent)) begin
            grant = GNT_WRITE;
        end else if (RD_REQ && !RST) begin
            grant = GNT_READ;
        end
    end

    // RAM command: out-of-range accesses are consumed without touching
    // the RAM and only raise the error flag.
    always_comb begin
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        oorHit    = 1'b0;
        case (grant)
            GNT_WRITE: begin
                if (inRange(head.addr)) begin
                    MEM_EN    = 1'b1;
                    MEM_WE    = 1'b1;
                    MEM_ADDR  = head.addr;
                    MEM_WDATA = head.data;
                end else begin
                    oorHit = 1'b1;
                end
            end
            GNT_READ: begin
                if (inRange(RD_ADDR)) begin
                    MEM_EN   = 1'b1;
                    MEM_ADDR = RD_ADDR;
                end else begin
                    oorHit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state for the starve counter, read pipeline and error flag.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!pend || grant == GNT_WRITE) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != STARVE_W'(STARVE_MAX)) begin
            starveCnt_d = starveCnt_q + STARVE_W'(1);
        end
        rdValid_d = (grant == GNT_READ);
        rdOor_d   = (grant == GNT_READ) & ~inRange(RD_ADDR);
        errOor_d  = errOor_q | oorHit;
    end

    // State registers, all cleared by the synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starveCnt_q <= '0;
            rdValid_q   <= 1'b0;
            rdOor_q     <= 1'b0;
            errOor_q    <= 1'b0;
        end else begin
            starveCnt_q <= starveCnt_d;
            rdValid_q   <= rdValid_d;
            rdOor_q     <= rdOor_d;
            errOor_q    <= errOor_d;
        end
    end

    // Outputs are masked by RST so a read in flight when reset arrives
    // never surfaces, and stale state is hidden during the reset cycle.
    assign RD_GNT     = (grant == GNT_READ);
    assign RD_VALID   = rdValid_q & ~RST;
    assign RD_DATA    = (RD_VALID && !rdOor_q) ? MEM_RDATA : '0;
    assign FIFO_LEVEL = RST ? '0 : level;
    assign ERR_OOR    = errOor_q & ~RST;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a behavioural
// single-port RAM attached to the MEM_* port.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    logic              CLK      = 1'b0;
    logic              RST      = 1'b1;
    logic              FLUSH    = 1'b0;
    logic              WR_VALID = 1'b0;
    logic [ADDR_W-1:0] WR_ADDR  = '0;
    logic [DATA_W-1:0] WR_DATA  = '0;
    logic              WR_READY;
    logic              RD_REQ   = 1'b0;
    logic [ADDR_W-1:0] RD_ADDR  = '0;
    logic              RD_GNT;
    logic              RD_VALID;
    logic [DATA_W-1:0] RD_DATA;
    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA = 2'b11;
    logic [2:0]        FIFO_LEVEL;
    logic              ERR_OOR;

    logic [DATA_W-1:0] tbRam   [FB_PIXELS] = '{default: '0};
    logic [DATA_W-1:0] expMem  [FB_PIXELS] = '{default: '0};
    bit                touched [FB_PIXELS];

    int vecCount = 0;
    int errCount = 0;

    fb_port_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .WR_VALID  (WR_VALID),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .WR_READY  (WR_READY),
        .RD_REQ    (RD_REQ),
        .RD_ADDR   (RD_ADDR),
        .RD_GNT    (RD_GNT),
        .RD_VALID  (RD_VALID),
        .RD_DATA   (RD_DATA),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .FIFO_LEVEL(FIFO_LEVEL),
        .ERR_OOR   (ERR_OOR)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM: one-cycle read latency, read data parked at 2'b11
    // when no read was issued so a missing zero-force is visible.
    always @(posedge CLK) begin
        if (MEM_EN && MEM_WE && inRange(MEM_ADDR)) begin
            tbRam[MEM_ADDR] <= MEM_WDATA;
        end
        if (MEM_EN && !MEM_WE && inRange(MEM_ADDR)) begin
            MEM_RDATA <= tbRam[MEM_ADDR];
        end else begin
            MEM_RDATA <= 2'b11;
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            RST = 1'b1; WR_VALID = 1'b1; WR_ADDR = 15'd7; WR_DATA = 2'd1;
            RD_REQ = 1'b1; RD_ADDR = 15'd9;
            #1;
            vecCount++;
            if ({WR_READY, RD_GNT, MEM_EN, RD_VALID, ERR_OOR, FIFO_LEVEL} !== 8'b0) begin
                errCount++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b required 00000000", i,
                         {WR_READY, RD_GNT, MEM_EN, RD_VALID, ERR_OOR, FIFO_LEVEL});
            end
        end
        @(negedge CLK);
        RST = 1'b0; WR_VALID = 1'b0; RD_REQ = 1'b0;
        #1;
        vecCount++;
        if (WR_READY !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", WR_READY);
        end
    endtask

    task automatic test_write_only();
        @(negedge CLK);
        WR_VALID = 1'b1; WR_ADDR = 15'd0; WR_DATA = 2'd1;
        #1;
        vecCount++;
        if ({WR_READY, MEM_EN} !== 2'b10) begin
            errCount++;
            $display("[TB] FAIL wr_first_push: got ready/en %b required 10", {WR_READY, MEM_EN});
        end
        @(negedge CLK);
        WR_ADDR = 15'd23039; WR_DATA = 2'd3;
        #1;
        vecCount++;
        if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, FIFO_LEVEL} !== {1'b1, 1'b1, 15'd0, 2'd1, 3'd1}) begin
            errCount++;
            $display("[TB] FAIL wr_mem_addr0: got en%b we%b a%0d d%0d lvl%0d required en1 we1 a0 d1 lvl1",
                     MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, FIFO_LEVEL);
        end
        @(negedge CLK);
        WR_VALID = 1'b0;
        #1;
        vecCount++;
        if ({MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 1'b1, 15'd23039, 2'd3}) begin
            errCount++;
            $display("[TB] FAIL wr_mem_addr_last: got en%b we%b a%0d d%0d required en1 we1 a23039 d3",
                     MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        @(negedge CLK);
        #1;
        vecCount++;
        if ({MEM_EN, FIFO_LEVEL} !== 4'b0) begin
            errCount++;
            $display("[TB] FAIL wr_drained: got en%b lvl%0d required en0 lvl0", MEM_EN, FIFO_LEVEL);
        end
    endtask

    task automatic test_read_only();
        int grants;
        logic [DATA_W-1:0] expData;
        grants = 0;
        // Preload addresses 5..15 through the write path: addr 5 holds 2,
        // addr a (6..15) holds a%4.
        for (int i = 0; i <= 10; i++) begin
            @(negedge CLK);
            WR_VALID = 1'b1; WR_ADDR = ADDR_W'(5 + i);
            WR_DATA = (i == 0) ? 2'd2 : DATA_W'((5 + i) % 4);
        end
        @(negedge CLK); WR_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RD_REQ = 1'b1; RD_ADDR = 15'd5;
        #1;
        vecCount++;
        if ({RD_GNT, MEM_EN, MEM_WE, MEM_ADDR} !== {1'b1, 1'b1, 1'b0, 15'd5}) begin
            errCount++;
            $display("[TB] FAIL rd_grant_addr5: got gnt%b en%b we%b a%0d required gnt1 en1 we0 a5",
                     RD_GNT, MEM_EN, MEM_WE, MEM_ADDR);
        end
        @(negedge CLK);
        RD_REQ = 1'b0;
        #1;
        vecCount++;
        if ({RD_VALID, RD_DATA, RD_GNT} !== {1'b1, 2'd2, 1'b0}) begin
            errCount++;
            $display("[TB] FAIL rd_data_addr5: got valid%b data%0d gnt%b required valid1 data2 gnt0",
                     RD_VALID, RD_DATA, RD_GNT);
        end
        for (int i = 0; i <= 10; i++) begin
            @(negedge CLK);
            RD_REQ = (i < 10); RD_ADDR = ADDR_W'(6 + i);
            #1;
            if (RD_GNT) grants++;
            if (i > 0) begin
                expData = DATA_W'((5 + i) % 4);
                vecCount++;
                if (RD_VALID !== 1'b1 || RD_DATA !== expData) begin
                    errCount++;
                    $display("[TB] FAIL rd_burst_data %0d: got valid%b data%0d required valid1 data%0d",
                             i - 1, RD_VALID, RD_DATA, expData);
                end
            end
        end
        vecCount++;
        if (grants != 10) begin
            errCount++;
            $display("[TB] FAIL rd_burst_grants: got %0d required 10", grants);
        end
    endtask

    task automatic test_starvation();
        int denied, badRead;
        bit granted;
        denied = 0; badRead = 0; granted = 0;
        @(negedge CLK);
        WR_VALID = 1'b1; WR_ADDR = 15'd200; WR_DATA = 2'd2;
        RD_REQ = 1'b1; RD_ADDR = 15'd100;
        #1;
        vecCount++;
        if (RD_GNT !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL starve_first_read: got %b required 1", RD_GNT);
        end
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge CLK);
            WR_VALID = 1'b0;
            #1;
            if (MEM_EN && MEM_WE) begin
                granted = 1;
                vecCount++;
                if ({MEM_ADDR, MEM_WDATA, RD_GNT} !== {15'd200, 2'd2, 1'b0}) begin
                    errCount++;
                    $display("[TB] FAIL starve_write: got a%0d d%0d gnt%b required a200 d2 gnt0",
                             MEM_ADDR, MEM_WDATA, RD_GNT);
                end
            end else begin
                denied++;
                if (RD_GNT !== 1'b1) badRead++;
            end
        end
        vecCount++;
        if (!granted || denied != 8) begin
            errCount++;
            $display("[TB] FAIL starve_denials: got %0d denied (granted=%0b) required 8 then grant",
                     denied, granted);
        end
        vecCount++;
        if (badRead != 0) begin
            errCount++;
            $display("[TB] FAIL starve_reads: got %0d denied cycles without RD_GNT required 0", badRead);
        end
        @(negedge CLK);
        #1;
        vecCount++;
        if ({RD_GNT, MEM_WE} !== 2'b10) begin
            errCount++;
            $display("[TB] FAIL starve_resume: got gnt%b we%b required gnt1 we0", RD_GNT, MEM_WE);
        end
        @(negedge CLK);
        RD_REQ = 1'b0;
    endtask

    task automatic test_urgency();
        int pushes, writes, urgentMiss, readyBad;
        bit sawLevel3;
        pushes = 0; writes = 0; urgentMiss = 0; readyBad = 0; sawLevel3 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            RD_REQ = 1'b1; RD_ADDR = 15'd101;
            WR_VALID = (i < 6); WR_ADDR = ADDR_W'(300 + i); WR_DATA = DATA_W'((i + 1) % 4);
            #1;
            if (WR_VALID && WR_READY) pushes++;
            if (MEM_EN && MEM_WE) writes++;
            if (FIFO_LEVEL >= 3'd3) begin
                sawLevel3 = 1;
                if (!(MEM_EN && MEM_WE)) urgentMiss++;
            end
            if (i < 6 && WR_READY !== 1'b1) readyBad++;
        end
        vecCount++;
        if (pushes != 6 || writes != 6) begin
            errCount++;
            $display("[TB] FAIL urgent_counts: got %0d pushes %0d writes required 6 and 6", pushes, writes);
        end
        vecCount++;
        if (!sawLevel3 || urgentMiss != 0) begin
            errCount++;
            $display("[TB] FAIL urgent_grant: got level3 seen=%0b misses=%0d required seen=1 misses=0",
                     sawLevel3, urgentMiss);
        end
        vecCount++;
        if (readyBad != 0) begin
            errCount++;
            $display("[TB] FAIL urgent_ready: got %0d not-ready cycles required 0", readyBad);
        end
        vecCount++;
        if (FIFO_LEVEL !== 3'd0) begin
            errCount++;
            $display("[TB] FAIL urgent_drained: got level %0d required 0", FIFO_LEVEL);
        end
        for (int i = 0; i < 6; i++) begin
            vecCount++;
            if (tbRam[300 + i] !== DATA_W'((i + 1) % 4)) begin
                errCount++;
                $display("[TB] FAIL urgent_ram[%0d]: got %0d required %0d", 300 + i, tbRam[300 + i], (i + 1) % 4);
            end
        end
        @(negedge CLK);
        RD_REQ = 1'b0;
    endtask

    task automatic test_flush();
        int writes;
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            RD_REQ = 1'b1; RD_ADDR = 15'd102;
            WR_VALID = 1'b1; WR_ADDR = ADDR_W'(400 + i); WR_DATA = 2'd3;
        end
        @(negedge CLK);
        WR_VALID = 1'b0; FLUSH = 1'b1;
        #1;
        vecCount++;
        if ({FIFO_LEVEL, MEM_WE, WR_READY, RD_GNT} !== {3'd3, 1'b0, 1'b0, 1'b1}) begin
            errCount++;
            $display("[TB] FAIL flush_cycle: got lvl%0d we%b rdy%b gnt%b required lvl3 we0 rdy0 gnt1",
                     FIFO_LEVEL, MEM_WE, WR_READY, RD_GNT);
        end
        @(negedge CLK);
        FLUSH = 1'b0;
        #1;
        vecCount++;
        if (FIFO_LEVEL !== 3'd0) begin
            errCount++;
            $display("[TB] FAIL flush_level: got %0d required 0", FIFO_LEVEL);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            #1;
            if (MEM_EN && MEM_WE) writes++;
        end
        RD_REQ = 1'b0;
        vecCount++;
        if (writes != 0 || tbRam[400] !== 2'd0 || tbRam[401] !== 2'd0 || tbRam[402] !== 2'd0) begin
            errCount++;
            $display("[TB] FAIL flush_no_writes: got %0d writes ram=%0d/%0d/%0d required 0 writes ram=0/0/0",
                     writes, tbRam[400], tbRam[401], tbRam[402]);
        end
    endtask

    task automatic test_oor();
        @(negedge CLK);
        WR_VALID = 1'b0; RD_REQ = 1'b0;
        #1;
        vecCount++;
        if (ERR_OOR !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL oor_initial: got %b required 0", ERR_OOR);
        end
        @(negedge CLK);
        RD_REQ = 1'b1; RD_ADDR = 15'd30000;
        #1;
        vecCount++;
        if ({RD_GNT, MEM_EN} !== 2'b10) begin
            errCount++;
            $display("[TB] FAIL oor_read_grant: got gnt%b en%b required gnt1 en0", RD_GNT, MEM_EN);
        end
        @(negedge CLK);
        RD_ADDR = 15'd5;
        #1;
        vecCount++;
        if ({RD_VALID, RD_DATA, ERR_OOR, RD_GNT} !== 5'b10011) begin
            errCount++;
            $display("[TB] FAIL oor_read_result: got valid%b data%0d err%b gnt%b required valid1 data0 err1 gnt1",
                     RD_VALID, RD_DATA, ERR_OOR, RD_GNT);
        end
        @(negedge CLK);
        RST = 1'b1; RD_REQ = 1'b0;
        #1;
        vecCount++;
        if ({RD_VALID, RD_DATA, ERR_OOR} !== 4'b0) begin
            errCount++;
            $display("[TB] FAIL reset_midread: got valid%b data%0d err%b required all 0", RD_VALID, RD_DATA, ERR_OOR);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        vecCount++;
        if ({RD_VALID, ERR_OOR, WR_READY} !== 3'b001) begin
            errCount++;
            $display("[TB] FAIL reset_clears_err: got valid%b err%b rdy%b required valid0 err0 rdy1",
                     RD_VALID, ERR_OOR, WR_READY);
        end
        @(negedge CLK);
        WR_VALID = 1'b1; WR_ADDR = 15'd23040; WR_DATA = 2'd1;
        @(negedge CLK);
        WR_VALID = 1'b0;
        #1;
        vecCount++;
        if ({MEM_EN, FIFO_LEVEL} !== {1'b0, 3'd1}) begin
            errCount++;
            $display("[TB] FAIL oor_write_pop: got en%b lvl%0d required en0 lvl1", MEM_EN, FIFO_LEVEL);
        end
        @(negedge CLK);
        #1;
        vecCount++;
        if ({ERR_OOR, FIFO_LEVEL} !== {1'b1, 3'd0}) begin
            errCount++;
            $display("[TB] FAIL oor_write_err: got err%b lvl%0d required err1 lvl0", ERR_OOR, FIFO_LEVEL);
        end
        repeat (5) @(negedge CLK);
        #1;
        vecCount++;
        if (ERR_OOR !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL oor_sticky: got %b required 1", ERR_OOR);
        end
    endtask

    task automatic test_random();
        int pushesLeft, cycles, bad;
        bit rdPending, expValid, done;
        logic [DATA_W-1:0] expData;
        pushesLeft = 46080; cycles = 0; bad = 0;
        rdPending = 0; expValid = 0; done = 0; expData = '0;
        for (int a = 0; a < FB_PIXELS; a++) touched[a] = 0;
        while (!done && cycles < 70000) begin
            @(negedge CLK);
            cycles++;
            if (pushesLeft > 0) begin
                WR_VALID = 1'b1;
                WR_ADDR  = ADDR_W'($urandom_range(FB_PIXELS - 1));
                WR_DATA  = DATA_W'($urandom_range(3));
            end else begin
                WR_VALID = 1'b0;
            end
            if (!rdPending && $urandom_range(7) == 0) begin
                rdPending = 1;
                RD_ADDR = ADDR_W'($urandom_range(FB_PIXELS - 1));
            end
            RD_REQ = rdPending;
            #1;
            vecCount++;
            if (RD_VALID !== expValid || (expValid && RD_DATA !== expData)) begin
                errCount++;
                $display("[TB] FAIL random_read cycle %0d: got valid%b data%0d required valid%b data%0d",
                         cycles, RD_VALID, RD_DATA, expValid, expData);
            end
            if (RD_GNT) begin
                expValid = 1;
                expData = tbRam[RD_ADDR];
                rdPending = 0;
            end else begin
                expValid = 0;
            end
            if (WR_VALID && WR_READY) begin
                expMem[WR_ADDR] = WR_DATA;
                touched[WR_ADDR] = 1;
                pushesLeft--;
            end
            done = (pushesLeft == 0) && (FIFO_LEVEL == 3'd0) && !rdPending && !expValid && !WR_VALID;
        end
        vecCount++;
        if (!done) begin
            errCount++;
            $display("[TB] FAIL random_timeout: got %0d pushes left after %0d cycles required drain", pushesLeft, cycles);
        end
        @(negedge CLK);
        WR_VALID = 1'b0; RD_REQ = 1'b0;
        @(negedge CLK);
        for (int a = 0; a < FB_PIXELS; a++) begin
            if (touched[a] && tbRam[a] !== expMem[a]) bad++;
        end
        vecCount++;
        if (bad != 0) begin
            errCount++;
            $display("[TB] FAIL random_ram: got %0d differing pixels required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_read_only();
        test_starvation();
        test_urgency();
        test_flush();
        test_oor();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
